param_fifo: RTL and testbench
=============================

// Module: param_fifo
// PURPOSE
//  Parametrised synchronous FIFO, the successor to the fixed 16-bit FIFO used on the data path.
//  Adds configurable width and depth, occupancy count, almost-full and almost-empty thresholds,
//  overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode.
//  Single clock domain. Sits between a producer using the we/data_in handshake and a consumer using re/data_out.
// PARAMETERS
//  WIDTH      16  data word width in bits
//  DEPTH      8   number of entries; power of two, >= 2
//  AFULL_TH   6   almost_full asserts when count >= AFULL_TH (1..DEPTH-1)
//  AEMPTY_TH  1   almost_empty asserts when count <= AEMPTY_TH (0..DEPTH-2)
//  FWFT       0   0 = standard registered read; 1 = first-word-fall-through
// PORTS
//  clk           in   1               clock; all logic samples on the rising edge
//  rst           in   1               asynchronous reset, active-low
//  data_in       in   WIDTH           write data, sampled when we=1
//  we            in   1               write request
//  re            in   1               read request
//  data_out      out  WIDTH           read data
//  fifo_full     out  1               count == DEPTH
//  fifo_empty    out  1               count == 0
//  almost_full   out  1               count >= AFULL_TH
//  almost_empty  out  1               count <= AEMPTY_TH
//  count         out  $clog2(DEPTH)+1 current occupancy, 0..DEPTH
//  overflow      out  1               1-cycle pulse: write rejected
//  underflow     out  1               1-cycle pulse: read rejected
// BEHAVIOUR
//  Reset (rst=0, async):
//  - Pointers and count are set to 0. data_out=0, fifo_empty=1, almost_empty=1, fifo_full=0,
//    almost_full=0, overflow=0, underflow=0.
//  - Memory contents are not reset.
//  - Reset asserted mid-operation discards all stored words immediately.
//  Accept rules, evaluated at each edge from pre-edge state:
//  - rd_ok = re & !fifo_empty.
//  - wr_ok = we & (!fifo_full | rd_ok). A write to a full FIFO is accepted only with a same-cycle accepted read.
//  - A read from an empty FIFO is rejected even if a write occurs in the same cycle. The write still proceeds.
//  - count_next = count + wr_ok - rd_ok. Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
//  - overflow  <= we & !wr_ok.
//  - underflow <= re & !rd_ok.
//  - Both error pulses are registered, high for exactly 1 cycle per rejected request, and change no state.
//  Flags:
//  - All flags are pure functions of the count register, so they update on the same edge as count.
//  - No combinational path from we/re to any flag.
//  FWFT=0:
//  - On rd_ok, data_out <= mem[rd_ptr] at that edge (1-cycle read latency).
//  - Otherwise data_out holds its value.
//  FWFT=1:
//  - data_out = mem[rd_ptr] whenever !fifo_empty; the head word is visible with no re.
//  - rd_ok advances to the next word.
//  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
//  - While empty, data_out holds the last presented word (0 after reset).
//  Ordering: strict FIFO. Words leave in write order with no loss or duplication across pointer wrap.
// TESTING
//  1. Reset with we=re=0 -> count=0, fifo_empty=1, almost_empty=1, fifo_full=0, data_out=0.
//  2. FWFT=0, DEPTH=8: write 1..8 on consecutive cycles ->
//     count=8, fifo_full=1, almost_full set when count reaches 6;
//     9th write -> overflow pulse 1 cycle, count stays 8.
//  3. From full, assert we=1 (data 9) and re=1 together for 1 cycle ->
//     data_out=1 next cycle, count stays 8; then drain -> outputs 2..9 in order.
//  4. Empty FIFO, re=1 and we=1 (data 0xA5A5) in the same cycle ->
//     underflow pulse, count=1, next read returns 0xA5A5.
//  5. FWFT=1: write 0x0011 to empty FIFO ->
//     data_out=0x0011 the next cycle with re=0; re=1 one cycle -> count=0, fifo_empty=1.
//  6. Wrap and reset: run 20 interleaved writes/reads (values 1..20) -> output sequence 1..20;
//     drop rst mid-burst -> flags return to reset values asynchronously, before the next edge.

Source files
------------

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, overflow/underflow pulses and an optional first-word-fall-through read.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous reset, active-low
//   data_in       write data, sampled when we=1
//   we, re        write / read requests
//   data_out      read data (registered in both read modes)
//   fifo_full     count == DEPTH
//   fifo_empty    count == 0
//   almost_full   count >= AFULL_TH
//   almost_empty  count <= AEMPTY_TH
//   count         occupancy, 0..DEPTH
//   overflow      one-cycle pulse for a rejected write
//   underflow     one-cycle pulse for a rejected read
module param_fifo #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AFULL_TH  = 6,
    parameter int unsigned AEMPTY_TH = 1,
    parameter int unsigned FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     we,
    input  logic                     re,
    output logic [WIDTH-1:0]         data_out,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic             rd_ok;
    logic             wr_ok;
    logic [CW-1:0]    count_next;
    logic [AW-1:0]    head_ptr_next;
    logic [WIDTH-1:0] head_next;
    logic [WIDTH-1:0] data_next;

    // Accept decisions, next occupancy and next data_out from pre-edge state
    always_comb begin
        rd_ok = re & (count != '0);
        wr_ok = we & ((count != CW'(DEPTH)) | rd_ok);

        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase

        // Head word after this edge; bypass the memory when the head slot is being written now
        head_ptr_next = rd_ptr + AW'(rd_ok);
        if (wr_ok && (head_ptr_next == wr_ptr)) begin
            head_next = data_in;
        end else begin
            head_next = mem[head_ptr_next];
        end

        data_next = data_out;
        if (FWFT != 0) begin
            // Present the head whenever non-empty; hold the last word while empty
            if (count_next != '0) begin
                data_next = head_next;
            end
        end else if (rd_ok) begin
            data_next = mem[rd_ptr];
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy, flags, data and error pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            data_out     <= '0;
            fifo_full    <= 1'b0;
            fifo_empty   <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count        <= count_next;
            data_out     <= data_next;
            fifo_full    <= (count_next == CW'(DEPTH));
            fifo_empty   <= (count_next == '0);
            almost_full  <= (count_next >= CW'(AFULL_TH));
            almost_empty <= (count_next <= CW'(AEMPTY_TH));
            overflow     <= we & ~wr_ok;
            underflow    <= re & ~rd_ok;
        end
    end

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: a standard-read and an FWFT instance share one stimulus
// stream and are checked every cycle against a queue-based model, plus directed
// scenarios with hand-computed expectations.
module tb_param_fifo;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AFTH  = 6;
    localparam int unsigned AETH  = 1;

    logic             clk;
    logic             rst;
    logic             we;
    logic             re;
    logic [WIDTH-1:0] data_in;

    logic [WIDTH-1:0] s_dout, f_dout;
    logic             s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic             f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [3:0]       s_cnt, f_cnt;

    int vectors = 0;
    int errors  = 0;
    bit check_en = 0;

    param_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFTH), .AEMPTY_TH(AETH), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .data_in(data_in), .we(we), .re(re),
        .data_out(s_dout), .fifo_full(s_full), .fifo_empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
        .overflow(s_ovf), .underflow(s_unf)
    );

    param_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFTH), .AEMPTY_TH(AETH), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .data_in(data_in), .we(we), .re(re),
        .data_out(f_dout), .fifo_full(f_full), .fifo_empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
        .overflow(f_ovf), .underflow(f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of stored words plus the two data_out views
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_std  = '0;
    logic [WIDTH-1:0] m_fwft = '0;
    logic             m_ovf  = 1'b0;
    logic             m_unf  = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_std  = '0;
            m_fwft = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            bit r_ok, w_ok;
            r_ok = re && (mq.size() > 0);
            w_ok = we && ((mq.size() < DEPTH) || r_ok);
            if (r_ok) m_std = mq.pop_front();
            if (w_ok) mq.push_back(data_in);
            m_ovf = we && !w_ok;
            m_unf = re && !r_ok;
            if (mq.size() > 0) m_fwft = mq[0];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_inst(input string tag, input logic [WIDTH-1:0] dout, input logic [3:0] cnt,
                            input logic full, input logic empty, input logic af, input logic ae,
                            input logic ovf, input logic unf, input logic [WIDTH-1:0] exp_dout);
        int n;
        n = mq.size();
        chk({tag, ".count"},        32'(cnt),   32'(n));
        chk({tag, ".fifo_full"},    32'(full),  32'(n == DEPTH));
        chk({tag, ".fifo_empty"},   32'(empty), 32'(n == 0));
        chk({tag, ".almost_full"},  32'(af),    32'(n >= AFTH));
        chk({tag, ".almost_empty"}, 32'(ae),    32'(n <= AETH));
        chk({tag, ".overflow"},     32'(ovf),   32'(m_ovf));
        chk({tag, ".underflow"},    32'(unf),   32'(m_unf));
        chk({tag, ".data_out"},     32'(dout),  32'(exp_dout));
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (check_en) begin
            cmp_inst("std",  s_dout, s_cnt, s_full, s_empty, s_af, s_ae, s_ovf, s_unf, m_std);
            cmp_inst("fwft", f_dout, f_cnt, f_full, f_empty, f_af, f_ae, f_ovf, f_unf, m_fwft);
        end
    end

    // Apply one cycle of stimulus; called and returns 2 time units after a rising edge
    task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d);
        we = w;
        re = r;
        data_in = d;
        @(posedge clk);
        #2;
        we = 1'b0;
        re = 1'b0;
    endtask

    initial begin
        int wp, rp;
        rst = 1'b0;
        we = 1'b0;
        re = 1'b0;
        data_in = '0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Reset state
        chk("rst.count", 32'(s_cnt), 0);
        chk("rst.empty", 32'(s_empty), 1);
        chk("rst.aempty", 32'(s_ae), 1);
        chk("rst.full", 32'(s_full), 0);
        chk("rst.dout_std", 32'(s_dout), 0);
        chk("rst.dout_fwft", 32'(f_dout), 0);
        check_en = 1;

        // Fill 1..8, watch almost_full arrive at 6
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, WIDTH'(i));
            chk("fill.almost_full", 32'(s_af), 32'(i >= 6));
        end
        chk("fill.count", 32'(s_cnt), 8);
        chk("fill.full", 32'(s_full), 1);
        chk("fill.model_size", 32'(mq.size()), 8);
        step(1'b1, 1'b0, 16'd99);
        chk("ovf.pulse", 32'(s_ovf), 1);
        chk("ovf.count", 32'(s_cnt), 8);
        step(1'b0, 1'b0, '0);
        chk("ovf.cleared", 32'(s_ovf), 0);

        // Simultaneous write+read on full, then drain 2..9
        step(1'b1, 1'b1, 16'd9);
        chk("fullrw.dout", 32'(s_dout), 1);
        chk("fullrw.count", 32'(s_cnt), 8);
        chk("fullrw.fwft_head", 32'(f_dout), 2);
        for (int k = 2; k <= 9; k++) begin
            step(1'b0, 1'b1, '0);
            chk("drain.dout", 32'(s_dout), 32'(k));
        end
        chk("drain.empty", 32'(s_empty), 1);

        // Read+write on empty: read rejected, write kept
        step(1'b1, 1'b1, 16'hA5A5);
        chk("emptyrw.underflow", 32'(s_unf), 1);
        chk("emptyrw.count", 32'(s_cnt), 1);
        chk("emptyrw.fwft_dout", 32'(f_dout), 32'h0000A5A5);
        step(1'b0, 1'b1, '0);
        chk("emptyrw.read", 32'(s_dout), 32'h0000A5A5);
        chk("emptyrw.unf_clear", 32'(s_unf), 0);

        // FWFT fall-through of a single word, hold while empty
        step(1'b1, 1'b0, 16'h0011);
        chk("fwft.dout", 32'(f_dout), 32'h11);
        chk("fwft.count", 32'(f_cnt), 1);
        step(1'b0, 1'b1, '0);
        chk("fwft.count0", 32'(f_cnt), 0);
        chk("fwft.empty", 32'(f_empty), 1);
        chk("fwft.hold", 32'(f_dout), 32'h11);

        // 20 interleaved writes/reads across pointer wrap
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, i > 2, WIDTH'(i));
            if (i > 2) chk("wrap.seq", 32'(s_dout), 32'(i - 2));
        end
        step(1'b0, 1'b1, '0);
        chk("wrap.seq19", 32'(s_dout), 19);
        step(1'b0, 1'b1, '0);
        chk("wrap.seq20", 32'(s_dout), 20);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, WIDTH'(16'h100 + i));
        we = 1'b1;
        data_in = 16'h0BAD;
        #1;
        rst = 1'b0;
        #1;
        chk("arst.count", 32'(s_cnt), 0);
        chk("arst.empty", 32'(s_empty), 1);
        chk("arst.aempty", 32'(s_ae), 1);
        chk("arst.full", 32'(s_full), 0);
        chk("arst.afull", 32'(f_af), 0);
        chk("arst.dout_std", 32'(s_dout), 0);
        chk("arst.dout_fwft", 32'(f_dout), 0);
        we = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Randomized traffic in fill-biased, drain-biased and balanced phases
        for (int ph = 0; ph < 15; ph++) begin
            case (ph % 3)
                0:       begin wp = 80; rp = 30; end
                1:       begin wp = 25; rp = 80; end
                default: begin wp = 55; rp = 55; end
            endcase
            for (int c = 0; c < 100; c++) begin
                step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, WIDTH'($urandom));
            end
        end

        step(1'b0, 1'b0, '0);
        check_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
